byte_word_loader: RTL and testbench
===================================

// Module: byte_word_loader
// PURPOSE
//  Pin-side program loader: receives a byte stream on the TinyTapeout pins, packs it into 32-bit words,
//  writes them sequentially into the 32-bit RAM and holds the risc core stopped until loading ends.
//  Write-side counterpart of the word-to-byte output serializer: same byte order (byte 0 = bits [7:0]).
//  Sits between tt_um_risc pins (ui_in/uio_in) and the RAM write port; cpu_run gates the core.
// PARAMETERS
//  ADDR_W       5   word address width; DEPTH = 2**ADDR_W words (32)
//  SYNC_STAGES  2   flops in pin synchronizers for byte_strobe and load_en (>=2)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous, active-low reset
//  load_en      in   1       pin level (asynchronous); 1 = loading session, 0 = run
//  byte_strobe  in   1       pin (asynchronous); rising edge = byte_in valid
//  byte_in      in   8       data byte; host holds stable from >=1 clk before strobe rise until strobe fall
//  mem_we       out  1       one-cycle RAM write pulse
//  mem_addr     out  ADDR_W  RAM word address
//  mem_wdata    out  32      RAM write data
//  cpu_run      out  1       1 = core may execute; 0 = core held
//  busy         out  1       1 while in LOAD or WRITE
//  words_loaded out  ADDR_W+1 words written this session (0..DEPTH)
//  overflow     out  1       sticky: byte received with memory full
// BEHAVIOUR
//  Reset (async): mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, words_loaded=0, overflow=0,
//   state=IDLE, byte_cnt=0, word buffer=0. Reset mid-session discards partial word, no write issued.
//  Sync: load_en and byte_strobe via SYNC_STAGES flops; byte event = sync strobe 0->1 (one clk pulse).
//   Pin-edge to byte capture latency = SYNC_STAGES+1 clk. Strobe held high = exactly one byte.
//   Min event spacing 2 clk, so one-cycle WRITE never collides with a byte event.
//  FSM (state regs only in this module):
//   IDLE : cpu_run=0. sync load_en=1 -> LOAD (addr=0, byte_cnt=0, words_loaded=0, overflow=0).
//   LOAD : busy=1. byte event -> buf[8*byte_cnt +: 8] = byte_in, byte_cnt++ ; on 4th byte -> WRITE.
//          load_en=0 -> if byte_cnt!=0 WRITE (flush, unfilled bytes = 0x00) then RUN; else RUN.
//          Byte event and load_en fall same cycle: byte accepted first, then flush.
//   WRITE: one cycle, mem_we=1, mem_addr=addr, mem_wdata=buf; words_loaded++; buf=0, byte_cnt=0.
//          addr==DEPTH-1 -> FULL (mem_addr stays DEPTH-1, no wrap); else addr++, back to LOAD
//          (or RUN if this was a flush).
//   FULL : busy=0. any byte event -> overflow=1, byte dropped, no write. load_en=0 -> RUN.
//   RUN  : cpu_run=1. byte events ignored. load_en=1 -> LOAD; cpu_run drops in that same cycle.
//  mem_wdata/mem_addr hold last written values outside WRITE; mem_we only high in WRITE.
//  words_loaded saturates at DEPTH; overflow cleared only by reset or entering LOAD.
// STRUCTURE
//  risc_pkg: BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, state encoding localparams
//   (IDLE, LOAD, WRITE, FULL, RUN), shared with the output serializer.
//  Sub-module pin_sync_edge (SYNC_STAGES flops + rising-edge pulse), instantiated twice
//   (load_en uses level output, byte_strobe uses edge output).
// TESTING
//  1 Assert rst_n=0 mid-clock -> all outputs 0 immediately, without a clock edge.
//  2 load_en=1, bytes 78,56,34,12 -> single mem_we pulse, mem_addr=0, mem_wdata=0x12345678, words_loaded=1.
//  3 Continue AA,BB then load_en=0 -> write addr 1 data 0x0000BBAA, then cpu_run=1, busy=0, words_loaded=2.
//  4 Load 128 bytes + 1 extra -> 32 writes (addr 0..31), no 33rd mem_we, overflow=1, mem_addr=31.
//  5 Two bytes then rst_n pulse -> no mem_we, outputs 0; new session writes first word at addr 0.
//  6 Strobe held high 10 clk -> one byte captured; bytes sent in RUN -> no writes, state stays RUN.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the risc pin-side loader and the word-to-byte output
// serializer: data widths, byte order helper and the loader state encoding.
package risc_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FULL  = 3'd3,
        ST_RUN   = 3'd4
    } loader_state_t;

    // Place a byte into its lane of a word; lane 0 is bits [7:0].
    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0] word,
        input logic [BCNT_W-1:0] lane,
        input logic [BYTE_W-1:0] data
    );
        logic [WORD_W-1:0] result;
        result = word;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane == i[BCNT_W-1:0]) begin
                result[i*BYTE_W +: BYTE_W] = data;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with a one-cycle pulse on
// each rising edge of the synchronized level.
module pin_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
        end
    end

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~level_d;

endmodule

// File: rtl/byte_word_loader.sv
// Pin-side program loader: packs a strobed byte stream into 32-bit words,
// writes them sequentially into RAM and holds the core until loading ends.
module byte_word_loader
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              byte_strobe,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic [ADDR_W:0]   words_loaded,
    output logic              overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   WORDS_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [BCNT_W-1:0] LAST_LANE = BCNT_W'(BYTES_PER_WORD - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [BCNT_W-1:0] byte_cnt;
    logic [WORD_W-1:0] word_buf;
    logic              flush;

    logic              load_lvl;
    logic              load_rise;
    logic              strobe_lvl;
    logic              byte_ev;
    logic              unused_sync;
    logic [WORD_W-1:0] buf_next;

    pin_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_load (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (load_en),
        .level (load_lvl),
        .rise  (load_rise)
    );

    pin_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (byte_strobe),
        .level (strobe_lvl),
        .rise  (byte_ev)
    );

    assign unused_sync = load_rise ^ strobe_lvl;

    // Word buffer as it stands once the current byte event (if any) is merged.
    always_comb begin
        buf_next = word_buf;
        if (byte_ev) begin
            buf_next = insert_byte(word_buf, byte_cnt, byte_in);
        end
    end

    // Session FSM with registered RAM port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            addr         <= '0;
            byte_cnt     <= '0;
            word_buf     <= '0;
            flush        <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            words_loaded <= '0;
            overflow     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (load_lvl) begin
                        state        <= ST_LOAD;
                        busy         <= 1'b1;
                        cpu_run      <= 1'b0;
                        addr         <= '0;
                        byte_cnt     <= '0;
                        word_buf     <= '0;
                        words_loaded <= '0;
                        overflow     <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (byte_ev) begin
                        word_buf <= buf_next;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    // A byte arriving with the load_en fall is merged before the flush.
                    if (byte_ev && (byte_cnt == LAST_LANE)) begin
                        state     <= ST_WRITE;
                        flush     <= ~load_lvl;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= buf_next;
                    end else if (!load_lvl) begin
                        if (byte_ev || (byte_cnt != '0)) begin
                            state     <= ST_WRITE;
                            flush     <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= buf_next;
                        end else begin
                            state   <= ST_RUN;
                            busy    <= 1'b0;
                            cpu_run <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    word_buf <= '0;
                    byte_cnt <= '0;
                    flush    <= 1'b0;
                    if (words_loaded != WORDS_MAX) begin
                        words_loaded <= words_loaded + 1'b1;
                    end
                    if (addr == '1) begin
                        state <= ST_FULL;
                        busy  <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                        if (flush) begin
                            state   <= ST_RUN;
                            busy    <= 1'b0;
                            cpu_run <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end

                ST_FULL: begin
                    if (byte_ev) begin
                        overflow <= 1'b1;
                    end
                    if (!load_lvl) begin
                        state   <= ST_RUN;
                        cpu_run <= 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_word_loader.sv
// Randomized self-checking bench for byte_word_loader; expected RAM writes are
// derived from the list of bytes sent in each session.
module tb_byte_word_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_en = 1'b0;
    logic              byte_strobe = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic [ADDR_W:0]   words_loaded;
    logic              overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [7:0]        sent_q[$];

    byte_word_loader #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .byte_strobe  (byte_strobe),
        .byte_in      (byte_in),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .words_loaded (words_loaded),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Record every RAM write seen by the memory.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    // Reference: bytes fill words little-end first; only DEPTH words fit.
    function automatic int exp_words();
        int n;
        n = (sent_q.size() + 3) / 4;
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        w = 32'h0;
        for (int j = 0; j < 4; j++) begin
            if (4*k + j < sent_q.size()) w[8*j +: 8] = sent_q[4*k + j];
        end
        return w;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold, input bit record);
        @(negedge clk);
        byte_in = b;
        @(negedge clk);
        byte_strobe = 1'b1;
        repeat (hold) @(negedge clk);
        byte_strobe = 1'b0;
        repeat (3) @(negedge clk);
        if (record) sent_q.push_back(b);
    endtask

    task automatic start_session();
        @(negedge clk);
        sent_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        load_en = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic end_session();
        @(negedge clk);
        load_en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++;
        if ({mem_we, mem_addr, mem_wdata, cpu_run, busy, words_loaded, overflow} !== '0)
            $display("FAIL reset_state: got we=%b addr=%0d wdata=%h run=%b busy=%b wl=%0d ovf=%b, required all 0",
                     mem_we, mem_addr, mem_wdata, cpu_run, busy, words_loaded, overflow);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        start_session();
        total_cnt++;
        if (busy !== 1'b1 || cpu_run !== 1'b0) $display("FAIL load_busy: got busy=%b run=%b, required 1/0", busy, cpu_run);
        else pass_cnt++;
        send_byte(8'h78, 2, 1'b1);
        send_byte(8'h56, 3, 1'b1);
        send_byte(8'h34, 2, 1'b1);
        send_byte(8'h12, 4, 1'b1);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wr_addr_q.size() !== 1) $display("FAIL first_word_count: got %0d writes, required 1", wr_addr_q.size());
        else pass_cnt++;
        if (wr_addr_q.size() >= 1) begin
            total_cnt++;
            if (wr_addr_q[0] !== 5'd0 || wr_data_q[0] !== 32'h12345678)
                $display("FAIL first_word: got addr=%0d data=%h, required addr=0 data=12345678", wr_addr_q[0], wr_data_q[0]);
            else pass_cnt++;
        end
        total_cnt++;
        if (words_loaded !== 6'd1) $display("FAIL words_after_first: got %0d, required 1", words_loaded);
        else pass_cnt++;
        send_byte(8'hAA, 2, 1'b1);
        send_byte(8'hBB, 2, 1'b1);
        end_session();
        total_cnt++;
        if (wr_addr_q.size() !== 2) $display("FAIL flush_count: got %0d writes, required 2", wr_addr_q.size());
        else pass_cnt++;
        if (wr_addr_q.size() >= 2) begin
            total_cnt++;
            if (wr_addr_q[1] !== 5'd1 || wr_data_q[1] !== 32'h0000BBAA)
                $display("FAIL flush_word: got addr=%0d data=%h, required addr=1 data=0000bbaa", wr_addr_q[1], wr_data_q[1]);
            else pass_cnt++;
        end
        total_cnt++;
        if (cpu_run !== 1'b1 || busy !== 1'b0 || words_loaded !== 6'd2 || mem_we !== 1'b0)
            $display("FAIL run_after_flush: got run=%b busy=%b wl=%0d we=%b, required 1/0/2/0", cpu_run, busy, words_loaded, mem_we);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({mem_we, mem_addr, mem_wdata, cpu_run, busy, words_loaded, overflow} !== '0)
            $display("FAIL async_reset: got we=%b addr=%0d wdata=%h run=%b busy=%b wl=%0d ovf=%b, required all 0",
                     mem_we, mem_addr, mem_wdata, cpu_run, busy, words_loaded, overflow);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_session();
        start_session();
        send_byte(8'hC3, 2, 1'b0);
        send_byte(8'h5A, 2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        load_en = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || words_loaded !== '0 || mem_wdata !== '0)
            $display("FAIL mid_reset_outputs: got busy=%b wl=%0d wdata=%h, required 0", busy, words_loaded, mem_wdata);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (wr_addr_q.size() !== 0) $display("FAIL mid_reset_no_write: got %0d writes, required 0", wr_addr_q.size());
        else pass_cnt++;
        start_session();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 2, 1'b1);
        end_session();
        total_cnt++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 5'd0 || wr_data_q[0] !== exp_word(0))
            $display("FAIL post_reset_session: got %0d writes first addr=%0d data=%h, required 1 write addr=0 data=%h",
                     wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 5'd0,
                     (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, exp_word(0));
        else pass_cnt++;
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 5; s++) begin
            int nbytes;
            nbytes = (s == 0) ? 0 : $urandom_range(1, 24);
            start_session();
            for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), $urandom_range(2, 4), 1'b1);
            end_session();
            total_cnt++;
            if (wr_addr_q.size() !== exp_words())
                $display("FAIL rand_count s%0d: got %0d writes, required %0d", s, wr_addr_q.size(), exp_words());
            else pass_cnt++;
            for (int k = 0; k < wr_addr_q.size() && k < exp_words(); k++) begin
                total_cnt++;
                if (wr_addr_q[k] !== ADDR_W'(k) || wr_data_q[k] !== exp_word(k))
                    $display("FAIL rand_word s%0d w%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                             s, k, wr_addr_q[k], wr_data_q[k], k, exp_word(k));
                else pass_cnt++;
            end
            total_cnt++;
            if (words_loaded !== (ADDR_W+1)'(exp_words()) || cpu_run !== 1'b1 || overflow !== 1'b0)
                $display("FAIL rand_status s%0d: got wl=%0d run=%b ovf=%b, required wl=%0d run=1 ovf=0",
                         s, words_loaded, cpu_run, overflow, exp_words());
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        start_session();
        for (int i = 0; i < 4*DEPTH + 1; i++) send_byte(8'($urandom), 2, 1'b1);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (overflow !== 1'b1 || busy !== 1'b0 || cpu_run !== 1'b0 || mem_addr !== 5'd31)
            $display("FAIL full_state: got ovf=%b busy=%b run=%b addr=%0d, required 1/0/0/31", overflow, busy, cpu_run, mem_addr);
        else pass_cnt++;
        end_session();
        total_cnt++;
        if (wr_addr_q.size() !== DEPTH) $display("FAIL full_count: got %0d writes, required %0d", wr_addr_q.size(), DEPTH);
        else pass_cnt++;
        for (int k = 0; k < wr_addr_q.size() && k < DEPTH; k++) begin
            total_cnt++;
            if (wr_addr_q[k] !== ADDR_W'(k) || wr_data_q[k] !== exp_word(k))
                $display("FAIL full_word w%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         k, wr_addr_q[k], wr_data_q[k], k, exp_word(k));
            else pass_cnt++;
        end
        total_cnt++;
        if (words_loaded !== 6'd32 || overflow !== 1'b1 || cpu_run !== 1'b1 || mem_addr !== 5'd31)
            $display("FAIL full_run: got wl=%0d ovf=%b run=%b addr=%0d, required 32/1/1/31", words_loaded, overflow, cpu_run, mem_addr);
        else pass_cnt++;
        start_session();
        total_cnt++;
        if (overflow !== 1'b0 || words_loaded !== '0 || cpu_run !== 1'b0)
            $display("FAIL overflow_clear: got ovf=%b wl=%0d run=%b, required 0/0/0", overflow, words_loaded, cpu_run);
        else pass_cnt++;
        end_session();
    endtask

    task automatic test_strobe_hold_and_run();
        logic [7:0] b;
        b = 8'($urandom);
        start_session();
        send_byte(b, 10, 1'b1);
        end_session();
        total_cnt++;
        if (wr_addr_q.size() !== 1 || wr_data_q[0] !== {24'h0, b})
            $display("FAIL strobe_hold: got %0d writes data=%h, required 1 write data=%h",
                     wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, {24'h0, b});
        else pass_cnt++;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 2, 1'b0);
        total_cnt++;
        if (wr_addr_q.size() !== 1 || cpu_run !== 1'b1 || busy !== 1'b0 || words_loaded !== 6'd1)
            $display("FAIL run_ignores_bytes: got writes=%0d run=%b busy=%b wl=%0d, required 1/1/0/1",
                     wr_addr_q.size(), cpu_run, busy, words_loaded);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_reset_mid_session();
        test_random_sessions();
        test_overflow();
        test_strobe_hold_and_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
